// File: rtl/rv_pipe_pkg.sv
// ---------------------------------------------------------------------------
// rv_pipe_pkg
// Shared definitions for the 5-stage RV32I pipeline control logic:
//   - major opcodes the hazard logic cares about (load, branch, jal)
//   - EX-stage operand forwarding select encodings
//   - state encoding of the hazard controller's memory-wait FSM
// No ports; imported with "import rv_pipe_pkg::*;".
// ---------------------------------------------------------------------------
package rv_pipe_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Forwarding mux selects: MEM result uses the upper bit, WB the lower.
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef enum logic [1:0] {
        S_RUN      = 2'b00,
        S_MEM_WAIT = 2'b01,
        S_TIMEOUT  = 2'b10
    } hz_state_t;

endpackage

// File: rtl/fwd_unit.sv
// ---------------------------------------------------------------------------
// fwd_unit
// Purely combinational EX-stage operand forwarding selection.
// Ports:
//   Rs1E, Rs2E          source registers of the instruction in EX
//   RdM, RegWriteM      destination / write enable of the instruction in MEM
//   RdW, RegWriteW      destination / write enable of the instruction in WB
//   ForwardAE/BE        select for rs1/rs2 operand (FWD_REG/FWD_MEM/FWD_WB)
// ---------------------------------------------------------------------------
module fwd_unit
    import rv_pipe_pkg::*;
(
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdM,
    input  logic       RegWriteM,
    input  logic [4:0] RdW,
    input  logic       RegWriteW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE
);

    // The MEM-stage result is younger than the WB one, so it wins when both
    // target the same register. x0 is never forwarded since it always reads 0.
    function automatic logic [1:0] pick(input logic [4:0] rs,
                                        input logic [4:0] rd_m, input logic we_m,
                                        input logic [4:0] rd_w, input logic we_w);
        if (we_m && (rd_m != 5'd0) && (rd_m == rs))
            return FWD_MEM;
        else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
            return FWD_WB;
        else
            return FWD_REG;
    endfunction

    assign ForwardAE = pick(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    assign ForwardBE = pick(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central hazard/sequencing controller for the 5-stage RV32I pipeline.
// Detects load-use hazards, taken redirects from EX and data-memory wait
// states, and drives the pipeline register stall/flush/bubble/freeze
// controls in the same cycle. Also supplies EX forwarding selects, keeps
// saturating performance counters and a sticky memory-timeout flag.
// Ports:
//   clk, rst                clock, asynchronous active-low reset
//   Rs1D, Rs2D              source registers of the instruction in ID
//   Rs1E, Rs2E, RdE         registers of the instruction in EX
//   MemReadE                EX instruction is a load
//   RdM/RegWriteM, RdW/RegWriteW  writers in MEM and WB
//   PCSrcE                  taken branch/JAL resolved in EX
//   dmem_req, dmem_ready    data memory handshake from MEM
//   StallF, StallD, FlushD, BubbleE, FreezeEM   pipeline controls
//   ForwardAE, ForwardBE    EX operand forwarding selects
//   stall_cycles, flush_events, memwait_cycles  saturating counters
//   mem_timeout_err         sticky data-memory timeout flag
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 64,
    parameter int TO_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic             MemReadE,
    input  logic [4:0]       RdM,
    input  logic             RegWriteM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             BubbleE,
    output logic             FreezeEM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic [CNT_W-1:0] memwait_cycles,
    output logic             mem_timeout_err
);

    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    hz_state_t       state;
    logic [TO_W-1:0] wait_cnt;
    logic [TO_W-1:0] wait_next;
    logic            mem_stall;
    logic            lu;
    logic            redirect;
    logic            lu_bubble;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;

    // Hazard terms, resolved by priority freeze > redirect > load-use.
    // A redirect makes the ID instruction wrong-path, so its load-use hazard
    // is irrelevant; while frozen nothing advances, so neither acts.
    assign mem_stall = dmem_req & ~dmem_ready;
    assign lu        = MemReadE & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));
    assign redirect  = PCSrcE & ~mem_stall;
    assign lu_bubble = lu & ~mem_stall & ~PCSrcE;
    assign wait_next = wait_cnt + TO_W'(1);

    // Same-cycle pipeline controls, all forced inactive while reset is held.
    always_comb begin
        FreezeEM = 1'b0;
        StallF   = 1'b0;
        StallD   = 1'b0;
        FlushD   = 1'b0;
        BubbleE  = 1'b0;
        if (rst) begin
            FreezeEM = mem_stall;
            StallF   = mem_stall | lu_bubble;
            StallD   = mem_stall | lu_bubble;
            FlushD   = redirect;
            BubbleE  = redirect | lu_bubble;
        end
    end

    fwd_unit u_fwd (
        .Rs1E      (Rs1E),
        .Rs2E      (Rs2E),
        .RdM       (RdM),
        .RegWriteM (RegWriteM),
        .RdW       (RdW),
        .RegWriteW (RegWriteW),
        .ForwardAE (fwd_a),
        .ForwardBE (fwd_b)
    );

    assign ForwardAE = rst ? fwd_a : FWD_REG;
    assign ForwardBE = rst ? fwd_b : FWD_REG;

    // Memory-wait FSM: wait_cnt counts consecutive stalled cycles so that a
    // hung data memory raises a sticky error after MEM_TIMEOUT cycles. Only
    // the error flag is observable; the freeze itself follows mem_stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= S_RUN;
            wait_cnt        <= '0;
            mem_timeout_err <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (mem_stall) begin
                        wait_cnt <= TO_W'(1);
                        if (TO_LIMIT <= TO_W'(1)) begin
                            state           <= S_TIMEOUT;
                            mem_timeout_err <= 1'b1;
                        end else begin
                            state <= S_MEM_WAIT;
                        end
                    end
                end
                S_MEM_WAIT: begin
                    if (!mem_stall) begin
                        state    <= S_RUN;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_next;
                        if (wait_next >= TO_LIMIT) begin
                            state           <= S_TIMEOUT;
                            mem_timeout_err <= 1'b1;
                        end
                    end
                end
                S_TIMEOUT: begin
                    if (!mem_stall) begin
                        state    <= S_RUN;
                        wait_cnt <= '0;
                    end
                end
                default: begin
                    state    <= S_RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Performance counters; they stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles   <= '0;
            flush_events   <= '0;
            memwait_cycles <= '0;
        end else begin
            if (lu_bubble && (stall_cycles != CNT_MAX))
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (redirect && (flush_events != CNT_MAX))
                flush_events <= flush_events + CNT_W'(1);
            if (mem_stall && (memwait_cycles != CNT_MAX))
                memwait_cycles <= memwait_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Self-checking bench for pipeline_hazard_ctrl, built with small counters
// (CNT_W=4) and a short timeout (MEM_TIMEOUT=4). Directed scenarios run
// first, followed by randomized cycles, all compared against a behavioural
// model that tracks event counts and stall run lengths.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 4;
    localparam int TO_W        = 8;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic             MemReadE, RegWriteM, RegWriteW, PCSrcE, dmem_req, dmem_ready;
    logic             StallF, StallD, FlushD, BubbleE, FreezeEM;
    logic [1:0]       ForwardAE, ForwardBE;
    logic [CNT_W-1:0] stall_cycles, flush_events, memwait_cycles;
    logic             mem_timeout_err;

    int checks   = 0;
    int failures = 0;

    // Reference model state: event totals and current stall run length.
    int m_stall   = 0;
    int m_flush   = 0;
    int m_memwait = 0;
    int m_run     = 0;
    bit m_err     = 1'b0;

    pipeline_hazard_ctrl #(
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_W        (TO_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .Rs1D            (Rs1D),
        .Rs2D            (Rs2D),
        .Rs1E            (Rs1E),
        .Rs2E            (Rs2E),
        .RdE             (RdE),
        .MemReadE        (MemReadE),
        .RdM             (RdM),
        .RegWriteM       (RegWriteM),
        .RdW             (RdW),
        .RegWriteW       (RegWriteW),
        .PCSrcE          (PCSrcE),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .StallF          (StallF),
        .StallD          (StallD),
        .FlushD          (FlushD),
        .BubbleE         (BubbleE),
        .FreezeEM        (FreezeEM),
        .ForwardAE       (ForwardAE),
        .ForwardBE       (ForwardBE),
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events),
        .memwait_cycles  (memwait_cycles),
        .mem_timeout_err (mem_timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic chk(input string tag, input string name,
                       input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s/%s observed=%0h expected=%0h", tag, name, observed, expected);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    function automatic logic [1:0] fwdExp(input logic [4:0] rs);
        if (!rst)                                   return 2'b00;
        if (RegWriteM && RdM != 0 && RdM == rs)     return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs)     return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit memStallNow();
        return dmem_req && !dmem_ready;
    endfunction

    function automatic bit loadUseNow();
        return MemReadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    endfunction

    task automatic applyStimulus(input logic [4:0] rs1d, input logic [4:0] rs2d,
                                 input logic [4:0] rde, input logic memrd,
                                 input logic pcsrc, input logic req, input logic ready);
        Rs1D       = rs1d;
        Rs2D       = rs2d;
        RdE        = rde;
        MemReadE   = memrd;
        PCSrcE     = pcsrc;
        dmem_req   = req;
        dmem_ready = ready;
    endtask

    task automatic setForward(input logic [4:0] rs1e, input logic [4:0] rs2e,
                              input logic [4:0] rdm, input logic rwm,
                              input logic [4:0] rdw, input logic rww);
        Rs1E      = rs1e;
        Rs2E      = rs2e;
        RdM       = rdm;
        RegWriteM = rwm;
        RdW       = rdw;
        RegWriteW = rww;
    endtask

    // Compare every output against the rules: freeze wins, then redirect,
    // then load-use; registered outputs against the model totals.
    task automatic checkOutput(input string tag);
        bit fz, sf, sd, fd, be;
        fz = 0; sf = 0; sd = 0; fd = 0; be = 0;
        if (rst) begin
            if (memStallNow()) begin
                fz = 1; sf = 1; sd = 1;
            end else if (PCSrcE) begin
                fd = 1; be = 1;
            end else if (loadUseNow()) begin
                sf = 1; sd = 1; be = 1;
            end
        end
        chk(tag, "FreezeEM", 32'(FreezeEM), 32'(fz));
        chk(tag, "StallF", 32'(StallF), 32'(sf));
        chk(tag, "StallD", 32'(StallD), 32'(sd));
        chk(tag, "FlushD", 32'(FlushD), 32'(fd));
        chk(tag, "BubbleE", 32'(BubbleE), 32'(be));
        chk(tag, "ForwardAE", 32'(ForwardAE), 32'(fwdExp(Rs1E)));
        chk(tag, "ForwardBE", 32'(ForwardBE), 32'(fwdExp(Rs2E)));
        chk(tag, "stall_cycles", 32'(stall_cycles), 32'(m_stall));
        chk(tag, "flush_events", 32'(flush_events), 32'(m_flush));
        chk(tag, "memwait_cycles", 32'(memwait_cycles), 32'(m_memwait));
        chk(tag, "mem_timeout_err", 32'(mem_timeout_err), 32'(m_err));
    endtask

    task automatic modelReset();
        m_stall = 0; m_flush = 0; m_memwait = 0; m_run = 0; m_err = 1'b0;
    endtask

    // Clock-edge update of the model from the inputs present at the edge.
    task automatic modelUpdate();
        if (!rst) return;
        if (memStallNow())      m_memwait = sat(m_memwait);
        else if (PCSrcE)        m_flush   = sat(m_flush);
        else if (loadUseNow())  m_stall   = sat(m_stall);
        m_run = memStallNow() ? m_run + 1 : 0;
        if (m_run >= MEM_TIMEOUT) m_err = 1'b1;
    endtask

    // Called at a negedge with inputs already applied; returns at the next.
    task automatic runCycle(input string tag);
        #1 checkOutput(tag);
        @(posedge clk);
        modelUpdate();
        #1 checkOutput(tag);
        @(negedge clk);
    endtask

    initial begin
        $display("[TB] starting pipeline_hazard_ctrl bench");
        @(negedge clk);

        // Reset held with every hazard present: all controls must stay idle.
        applyStimulus(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        setForward(5'd7, 5'd7, 5'd7, 1'b1, 5'd7, 1'b1);
        runCycle("in_reset");
        runCycle("in_reset");
        chk("in_reset", "FreezeEM_const", 32'(FreezeEM), 32'd0);

        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        setForward(5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        rst = 1'b1;
        runCycle("idle");

        // Load-use: lw x5 in EX, consumer reads x5 in ID.
        applyStimulus(5'd5, 5'd9, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        runCycle("load_use");
        chk("load_use", "stall_cycles_const", 32'(stall_cycles), 32'd1);
        applyStimulus(5'd5, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        runCycle("load_use_next");
        chk("load_use_next", "StallF_const", 32'(StallF), 32'd0);

        // Redirect coinciding with load-use: redirect wins.
        applyStimulus(5'd3, 5'd4, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        runCycle("redir_lu");
        chk("redir_lu", "flush_events_const", 32'(flush_events), 32'd1);
        chk("redir_lu", "stall_cycles_const", 32'(stall_cycles), 32'd1);

        // Forwarding priority.
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        setForward(5'd7, 5'd2, 5'd7, 1'b1, 5'd7, 1'b1);
        runCycle("fwd_mem");
        chk("fwd_mem", "ForwardAE_const", 32'(ForwardAE), 32'd2);
        setForward(5'd7, 5'd7, 5'd7, 1'b0, 5'd7, 1'b1);
        runCycle("fwd_wb");
        chk("fwd_wb", "ForwardBE_const", 32'(ForwardBE), 32'd1);
        setForward(5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        runCycle("fwd_x0");

        // Memory wait for 3 cycles with a redirect held across the freeze.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(5'd1, 5'd2, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0);
            runCycle("mem_wait");
        end
        applyStimulus(5'd1, 5'd2, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1);
        runCycle("mem_release");
        chk("mem_release", "memwait_const", 32'(memwait_cycles), 32'd3);
        chk("mem_release", "flush_const", 32'(flush_events), 32'd2);
        chk("mem_release", "err_const", 32'(mem_timeout_err), 32'd0);

        // Timeout: ready low for 6 cycles.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            runCycle("timeout");
            if (i == 2) chk("timeout", "err_before", 32'(mem_timeout_err), 32'd0);
            if (i == 3) chk("timeout", "err_at_limit", 32'(mem_timeout_err), 32'd1);
        end
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        runCycle("timeout_ready");
        chk("timeout_ready", "err_sticky", 32'(mem_timeout_err), 32'd1);

        // Asynchronous reset in the middle of a wait.
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        runCycle("pre_reset_wait");
        #2 rst = 1'b0;
        modelReset();
        #1 checkOutput("reset_mid_wait");
        chk("reset_mid_wait", "err_cleared", 32'(mem_timeout_err), 32'd0);
        @(negedge clk);
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        runCycle("after_reset");

        // Saturation: 20 back-to-back load-use bubbles.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(5'd6, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);
            runCycle("saturate");
        end
        chk("saturate", "stall_sat_const", 32'(stall_cycles), 32'd15);

        // Randomized traffic, with one reset pulse part way through.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
                          ($urandom_range(0, 2) != 0));
            setForward(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1),
                       5'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1));
            if (i == 200) begin
                #2 rst = 1'b0;
                modelReset();
                #1 checkOutput("rand_reset");
                @(negedge clk);
                rst = 1'b1;
            end
            runCycle("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
